add_scheduler: RTL and testbench
================================

ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of the single shared adder slice (bits per word).
REQ-002 Parameter NWORDS, default 4, SHALL set the number of words per operand; W = DATA_WIDTH*NWORDS; NWORDS >= 1.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-007 req_ready  out  2  per-requester accept strobe.
REQ-008 a0, b0  in  W  requester 0 operands.
REQ-009 cin0  in  1  requester 0 carry-in.
REQ-010 a1, b1  in  W  requester 1 operands.
REQ-011 cin1  in  1  requester 1 carry-in.
REQ-012 sum  out  W  result; meaningful only while res_valid=1.
REQ-013 cout  out  1  carry-out of the most significant word.
REQ-014 res_id  out  1  index of the requester that owns the result.
REQ-015 res_valid  out  1  result valid.
REQ-016 res_ready  in  1  downstream accept.

Function
REQ-017 The block SHALL have the states IDLE, RUN and DONE, plus a 1-bit round-robin pointer ptr.
REQ-018 In IDLE the grant SHALL be computed as follows: if only one req_valid bit is set, that requester is granted; if both are set, requester ptr is granted; if neither is set, there is no grant.
REQ-019 In IDLE, req_ready[g] SHALL be asserted combinationally for the granted requester g only; in RUN and DONE, req_ready SHALL be 2'b00.
REQ-020 On an IDLE edge with a grant, the block SHALL do all of the following:
- capture the granted a, b and cin into internal registers;
- set res_id=g;
- set ptr=~g;
- clear the word counter;
- go to RUN.
REQ-021 RUN SHALL last exactly NWORDS cycles. At each edge k (k=0..NWORDS-1), word k of sum SHALL be written with a_k+b_k+carry, where word k is bits [k*DATA_WIDTH +: DATA_WIDTH]. The carry register SHALL then be updated with the slice carry-out.
REQ-022 Only one DATA_WIDTH-bit addition per cycle SHALL be performed (single shared adder slice, LSW first).
REQ-023 At the last RUN edge, cout SHALL be written with the final carry and the state SHALL go to DONE; res_valid SHALL be 1 from that edge onward.
REQ-024 Latency SHALL be: res_valid rises NWORDS clock edges after the accepting edge.
REQ-025 In DONE, res_valid, sum, cout and res_id SHALL hold stable until an edge with res_ready=1. At that edge res_valid SHALL drop to 0 and the state SHALL return to IDLE. No new request SHALL be accepted in the same cycle.
REQ-026 res_ready SHALL be ignored in IDLE and RUN.
REQ-027 Changes on req_valid, a*, b* or cin* after acceptance SHALL NOT affect the result in flight.
REQ-028 Arithmetic SHALL be unsigned modulo 2^W; {cout,sum} SHALL equal a+b+cin exactly.
REQ-029 With NWORDS=1, RUN SHALL last one cycle and the protocol SHALL otherwise be identical.

Reset
REQ-030 While rst=1, regardless of clk, the block SHALL:
- set the state to IDLE and ptr to 0;
- clear the word counter and carry register;
- drive sum=0, cout=0, res_id=0, res_valid=0 and req_ready=2'b00.
REQ-031 Reset asserted mid-RUN or in DONE SHALL discard the result in flight; no res_valid pulse SHALL follow.
REQ-032 After rst deasserts, the first grant SHALL follow REQ-018 with ptr=0.

Verification (DATA_WIDTH=4, NWORDS=4 unless stated)
REQ-033 Single request: a0=16'h00FF, b0=16'h0001, cin0=0 -> req_ready=2'b01 at acceptance; 4 edges later res_valid=1, sum=16'h0100, cout=0, res_id=0.
REQ-034 Overflow: a1=16'hFFFF, b1=16'h0000, cin1=1 (req_valid=2'b10) -> sum=16'h0000, cout=1, res_id=1.
REQ-035 Contention: both req_valid held high from reset with res_ready=1 -> results return with res_id sequence 0,1,0,1; each request is accepted once per NWORDS+2 cycles.
REQ-036 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, sum, cout and res_id are stable and req_ready=2'b00; after res_ready=1 -> IDLE on the next edge.
REQ-037 Mid-run reset: rst pulsed on the 2nd RUN cycle -> no res_valid; a subsequent request a0=16'h1234, b0=16'h4321 completes with sum=16'h5555, res_id=0.
REQ-038 NWORDS=1: a0=4'h9, b0=4'h8, cin0=0 -> res_valid 1 edge after acceptance, sum=4'h1, cout=1.

Source files
------------

// File: rtl/add_scheduler.sv
// Two-requester round-robin adder that runs a W-bit add through one shared
// DATA_WIDTH-bit slice, least-significant word first, and holds the result until it is accepted.
module add_scheduler #(
  parameter int DATA_WIDTH = 4,
  parameter int NWORDS     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [DATA_WIDTH*NWORDS-1:0] a0,
  input  logic [DATA_WIDTH*NWORDS-1:0] b0,
  input  logic                         cin0,
  input  logic [DATA_WIDTH*NWORDS-1:0] a1,
  input  logic [DATA_WIDTH*NWORDS-1:0] b1,
  input  logic                         cin1,
  output logic [DATA_WIDTH*NWORDS-1:0] sum,
  output logic                         cout,
  output logic                         res_id,
  output logic                         res_valid,
  input  logic                         res_ready
);

  localparam int W  = DATA_WIDTH * NWORDS;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic                  ptr;
  logic [CW-1:0]         cnt;
  logic                  carry;
  logic [W-1:0]          a_r, b_r;
  logic                  gnt_any, g;
  logic [DATA_WIDTH-1:0] a_w, b_w, s_w;
  logic                  c_w;

  always_comb begin
    gnt_any = 1'b0;
    g       = 1'b0;
    case (req_valid)
      2'b01:   begin gnt_any = 1'b1; g = 1'b0; end
      2'b10:   begin gnt_any = 1'b1; g = 1'b1; end
      2'b11:   begin gnt_any = 1'b1; g = ptr;  end
      default: begin gnt_any = 1'b0; g = 1'b0; end
    endcase
    req_ready = '0;
    if (!rst && state == IDLE && gnt_any)
      req_ready[g] = 1'b1;
  end

  // Word select for the shared slice; cnt indexes the word being added this cycle.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (cnt == CW'(w)) begin
        a_w = a_r[w*DATA_WIDTH +: DATA_WIDTH];
        b_w = b_r[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    {c_w, s_w} = {1'b0, a_w} + {1'b0, b_w} + {{DATA_WIDTH{1'b0}}, carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            a_r    <= g ? a1 : a0;
            b_r    <= g ? b1 : b0;
            carry  <= g ? cin1 : cin0;
            res_id <= g;
            ptr    <= ~g;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < NWORDS; w++) begin
            if (cnt == CW'(w))
              sum[w*DATA_WIDTH +: DATA_WIDTH] <= s_w;
          end
          carry <= c_w;
          if (cnt == CW'(NWORDS - 1)) begin
            cout      <= c_w;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_scheduler.sv
// Self-checking bench for add_scheduler: a 4x4-bit instance and a single-word instance,
// checked against a reference model of round-robin arbitration and plain integer addition.
module tb_add_scheduler;

  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] a0, b0, a1, b1, sum;
  logic        cin0, cin1, cout, res_id, res_valid, res_ready;

  logic [1:0]  q_valid, q_ready;
  logic [3:0]  qa0, qb0, qa1, qb1, qsum;
  logic        qcin0, qcin1, qcout, qres_id, qres_valid, qres_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic mptr;
  logic qptr;

  always #5 clk = ~clk;

  add_scheduler #(.DATA_WIDTH(4), .NWORDS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .cin0(cin0), .a1(a1), .b1(b1), .cin1(cin1),
    .sum(sum), .cout(cout), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready)
  );

  add_scheduler #(.DATA_WIDTH(4), .NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready),
    .a0(qa0), .b0(qb0), .cin0(qcin0), .a1(qa1), .b1(qb1), .cin1(qcin1),
    .sum(qsum), .cout(qcout), .res_id(qres_id), .res_valid(qres_valid), .res_ready(qres_ready)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [15:0] a0, b0;
    logic        c0;
    logic [15:0] a1, b1;
    logic        c1;
    logic [1:0]  rdy;
    logic [15:0] s;
    logic        co;
    logic        id;
    int          hold;
  } vec_t;

  vec_t tv[7];

  int        acc_t[$];
  logic [1:0] acc_v[$];
  int        res_t[$];
  logic      res_i[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic scramble();
    a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
    a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
  endtask

  task automatic txn(input logic [1:0] rv, input logic [15:0] xa0, xb0, input logic xc0,
                     input logic [15:0] xa1, xb1, input logic xc1,
                     input logic [1:0] erdy, input logic [15:0] es, input logic eco,
                     input logic eid, input int hold);
    int lat;
    bit got;
    @(negedge clk);
    req_valid = rv; a0 = xa0; b0 = xb0; cin0 = xc0; a1 = xa1; b1 = xb1; cin1 = xc1;
    res_ready = 1'b0;
    #1;
    chk("req_ready at accept", 32'(req_ready), 32'(erdy));
    @(posedge clk); #1;
    // operands and requests change after acceptance; res_ready high during RUN must be ignored
    req_valid = '0;
    scramble();
    res_ready = 1'b1;
    lat = 0;
    got = 0;
    while (!got && lat <= 20) begin
      if (res_valid) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    res_ready = 1'b0;
    if (!got) begin
      chk("res_valid timeout", 32'(0), 32'(1));
      return;
    end
    chk("latency", 32'(lat), 32'(NW));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(eco));
    chk("res_id", 32'(res_id), 32'(eid));
    chk("req_ready in DONE", 32'(req_ready), 32'(0));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 2'b11;
      scramble();
      #1;
      chk("hold res_valid", 32'(res_valid), 32'(1));
      chk("hold sum", 32'(sum), 32'(es));
      chk("hold cout", 32'(cout), 32'(eco));
      chk("hold res_id", 32'(res_id), 32'(eid));
      chk("hold req_ready", 32'(req_ready), 32'(0));
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("res_valid after release", 32'(res_valid), 32'(0));
    if (hold > 0)
      chk("ready after release", 32'(req_ready), 32'(eid ? 2'b01 : 2'b10));
    res_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic txn1(input logic [1:0] rv, input logic [3:0] xa0, xb0, input logic xc0,
                      input logic [3:0] xa1, xb1, input logic xc1,
                      input logic [1:0] erdy, input logic [3:0] es, input logic eco, input logic eid);
    @(negedge clk);
    q_valid = rv; qa0 = xa0; qb0 = xb0; qcin0 = xc0; qa1 = xa1; qb1 = xb1; qcin1 = xc1;
    qres_ready = 1'b0;
    #1;
    chk("n1 req_ready", 32'(q_ready), 32'(erdy));
    @(posedge clk); #1;
    q_valid = '0;
    qa0 = 4'($urandom); qb0 = 4'($urandom); qa1 = 4'($urandom); qb1 = 4'($urandom);
    chk("n1 res_valid pre", 32'(qres_valid), 32'(0));
    @(posedge clk); #1;
    chk("n1 res_valid", 32'(qres_valid), 32'(1));
    chk("n1 sum", 32'(qsum), 32'(es));
    chk("n1 cout", 32'(qcout), 32'(eco));
    chk("n1 res_id", 32'(qres_id), 32'(eid));
    @(negedge clk);
    qres_ready = 1'b1;
    @(posedge clk); #1;
    chk("n1 release", 32'(qres_valid), 32'(0));
    qres_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rv;
    logic        g;
    logic [16:0] t;
    logic [4:0]  t1;
    int          npulse;

    tv[0] = '{2'b01, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'h0100, 1'b0, 1'b0, 0};
    tv[1] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 2'b10, 16'h0000, 1'b1, 1'b1, 0};
    tv[2] = '{2'b11, 16'h1111, 16'h2222, 1'b1, 16'h5555, 16'h5555, 1'b0, 2'b01, 16'h3334, 1'b0, 1'b0, 5};
    tv[3] = '{2'b11, 16'h0000, 16'h0000, 1'b0, 16'h8000, 16'h8000, 1'b0, 2'b10, 16'h0000, 1'b1, 1'b1, 2};
    tv[4] = '{2'b01, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'hFFFF, 1'b1, 1'b0, 0};
    tv[5] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 16'h0F0F, 16'hF0F0, 1'b1, 2'b10, 16'h0000, 1'b1, 1'b1, 1};
    tv[6] = '{2'b01, 16'hABCD, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'b01, 16'hBE01, 1'b0, 1'b0, 0};

    // reset holds everything at zero even with both requests raised
    rst = 1'b1;
    req_valid = 2'b11; res_ready = 1'b0;
    scramble();
    q_valid = 2'b11; qres_ready = 1'b0;
    qa0 = 4'h0; qb0 = 4'h0; qa1 = 4'h0; qb1 = 4'h0; qcin0 = 1'b0; qcin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sum", 32'(sum), 32'(0));
    chk("reset cout", 32'(cout), 32'(0));
    chk("reset res_id", 32'(res_id), 32'(0));
    chk("reset res_valid", 32'(res_valid), 32'(0));
    chk("reset req_ready", 32'(req_ready), 32'(0));
    chk("reset n1 req_ready", 32'(q_ready), 32'(0));
    @(negedge clk);
    req_valid = '0; q_valid = '0;
    rst = 1'b0;
    mptr = 1'b0;

    for (int i = 0; i < 7; i++) begin
      txn(tv[i].rv, tv[i].a0, tv[i].b0, tv[i].c0, tv[i].a1, tv[i].b1, tv[i].c1,
          tv[i].rdy, tv[i].s, tv[i].co, tv[i].id, tv[i].hold);
      mptr = ~tv[i].id;
    end

    // contention from reset: both requesters always valid, downstream always ready
    @(negedge clk);
    rst = 1'b1;
    res_ready = 1'b1; req_valid = 2'b11;
    a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
    a1 = 16'h0010; b1 = 16'h0020; cin1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 36; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        acc_t.push_back(c);
        acc_v.push_back(req_ready);
      end
      if (res_valid) begin
        chk("contention sum", 32'(sum), (res_t.size() % 2 == 1) ? 32'h0031 : 32'h0003);
        res_t.push_back(c);
        res_i.push_back(res_id);
      end
      @(negedge clk);
    end
    chk("contention accepts", 32'(acc_t.size()), 32'(6));
    chk("contention results", 32'(res_t.size()), 32'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < acc_t.size()) begin
        chk("contention grant", 32'(acc_v[i]), (i % 2 == 1) ? 32'h2 : 32'h1);
        if (i > 0) chk("contention period", 32'(acc_t[i] - acc_t[i-1]), 32'(NW + 2));
        if (i < res_t.size()) chk("contention latency", 32'(res_t[i] - acc_t[i]), 32'(NW + 1));
      end
      if (i < res_i.size()) chk("contention res_id", 32'(res_i[i]), 32'(i % 2));
    end
    req_valid = '0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    res_ready = 1'b0;

    // reset during the second RUN cycle discards the result and returns ptr to 0
    @(negedge clk);
    req_valid = 2'b01; a0 = 16'h00AA; b0 = 16'h0055; cin0 = 1'b0;
    #1;
    chk("midrun accept", 32'(req_ready), 32'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("midrun rst res_valid", 32'(res_valid), 32'(0));
    chk("midrun rst sum", 32'(sum), 32'(0));
    chk("midrun rst req_ready", 32'(req_ready), 32'(0));
    #2;
    rst = 1'b0;
    req_valid = '0;
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (res_valid) npulse++;
    end
    chk("midrun no pulse", 32'(npulse), 32'(0));
    txn(2'b11, 16'h1234, 16'h4321, 1'b0, 16'h0F00, 16'h0001, 1'b1, 2'b01, 16'h5555, 1'b0, 1'b0, 1);
    mptr = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra0, rb0, ra1, rb1;
      logic        rc0, rc1;
      rv  = 2'($urandom_range(1, 3));
      ra0 = 16'($urandom); rb0 = 16'($urandom); rc0 = 1'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom); rc1 = 1'($urandom);
      g = (rv == 2'b01) ? 1'b0 : (rv == 2'b10) ? 1'b1 : mptr;
      t = g ? (17'(ra1) + 17'(rb1) + 17'(rc1)) : (17'(ra0) + 17'(rb0) + 17'(rc0));
      txn(rv, ra0, rb0, rc0, ra1, rb1, rc1, g ? 2'b10 : 2'b01, t[15:0], t[16], g,
          int'($urandom_range(0, 3)));
      mptr = ~g;
    end

    qptr = 1'b0;
    txn1(2'b01, 4'h9, 4'h8, 1'b0, 4'h0, 4'h0, 1'b0, 2'b01, 4'h1, 1'b1, 1'b0);
    txn1(2'b10, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 1'b1, 2'b10, 4'h0, 1'b1, 1'b1);
    txn1(2'b11, 4'h3, 4'h4, 1'b1, 4'h7, 4'h7, 1'b0, 2'b01, 4'h8, 1'b0, 1'b0);
    qptr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [3:0] ra0, rb0, ra1, rb1;
      logic       rc0, rc1;
      rv  = 2'($urandom_range(1, 3));
      ra0 = 4'($urandom); rb0 = 4'($urandom); rc0 = 1'($urandom);
      ra1 = 4'($urandom); rb1 = 4'($urandom); rc1 = 1'($urandom);
      g = (rv == 2'b01) ? 1'b0 : (rv == 2'b10) ? 1'b1 : qptr;
      t1 = g ? (5'(ra1) + 5'(rb1) + 5'(rc1)) : (5'(ra0) + 5'(rb0) + 5'(rc0));
      txn1(rv, ra0, rb0, rc0, ra1, rb1, rc1, g ? 2'b10 : 2'b01, t1[3:0], t1[4], g);
      qptr = ~g;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
